md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_unit.sv | 99 +++++++++
 tb/tb_md_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: HI/LO op encodings and
// the fixed latencies of the iterative-looking (but operator-based) datapath.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101,
      MD_RSV6  = 3'b110,
      MD_RSV7  = 3'b111
   } md_op_e;

   localparam int unsigned MULT_CYCLES = 5;
   localparam int unsigned DIV_CYCLES  = 10;
   localparam int unsigned CNT_W       = 4;

   // Busy-cycle count loaded when a mult/div launches; zero for everything else.
   function automatic logic [CNT_W-1:0] op_latency(input md_op_e op);
      case (op)
         MD_MULT, MD_MULTU: op_latency = CNT_W'(MULT_CYCLES);
         MD_DIV,  MD_DIVU:  op_latency = CNT_W'(DIV_CYCLES);
         default:           op_latency = '0;
      endcase
   endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit. A launch latches the operands and op and
// loads a down-counter; HI/LO are written on the edge where the counter hits
// zero so the pipeline sees busy fall and the new HI/LO in the same cycle.
module md_unit
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_op_e           op_in;
   md_op_e           op_q;
   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic [CNT_W-1:0] cnt;

   logic             is_signed;
   logic [63:0]      a_ext;
   logic [63:0]      b_ext;
   logic [63:0]      prod;
   logic             neg_a;
   logic             neg_b;
   logic [31:0]      mag_a;
   logic [31:0]      mag_b;
   logic [31:0]      uquot;
   logic [31:0]      urem;
   logic             res_write;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;

   assign op_in = md_op_e'(op);
   assign busy  = (cnt != '0);

   // Result datapath on the latched operands. Signed divide works on
   // magnitudes and fixes signs afterwards, which also makes the
   // 0x80000000 / -1 overflow case wrap to 0x80000000 with remainder 0.
   always_comb begin
      is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
      a_ext     = {{32{is_signed & a_q[31]}}, a_q};
      b_ext     = {{32{is_signed & b_q[31]}}, b_q};
      prod      = a_ext * b_ext;
      neg_a     = is_signed & a_q[31];
      neg_b     = is_signed & b_q[31];
      mag_a     = neg_a ? (32'd0 - a_q) : a_q;
      mag_b     = neg_b ? (32'd0 - b_q) : b_q;
      uquot     = '0;
      urem      = '0;
      if (mag_b != '0) begin
         uquot = mag_a / mag_b;
         urem  = mag_a % mag_b;
      end
      res_write = 1'b1;
      res_hi    = prod[63:32];
      res_lo    = prod[31:0];
      if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
         res_write = (b_q != '0);
         res_lo    = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
         res_hi    = neg_a ? (32'd0 - urem) : urem;
      end
   end

   // Launch, countdown and HI/LO writeback; start is ignored while busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         a_q  <= '0;
         b_q  <= '0;
         op_q <= MD_MULT;
         hi   <= '0;
         lo   <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
         if ((cnt == CNT_W'(1)) && res_write) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end else if (start) begin
         case (op_in)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
               a_q  <= a;
               b_q  <= b;
               op_q <= op_in;
               cnt  <= op_latency(op_in);
            end
            MD_MTHI: hi <= a;
            MD_MTLO: lo <= a;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: an edge-count based reference model plus
// directed vectors with hand-computed HI/LO values.
module tb_md_unit;
   import md_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op    = 3'b000;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   bit cmpOn  = 1'b0;

   md_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // One comparison: counts it, reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: the completion is scheduled as an absolute edge number,
   // and the result is computed with plain integer arithmetic at launch.
   longint unsigned edgeCount = 0;
   longint unsigned doneEdge  = 0;
   bit              pendWrite = 1'b0;
   logic [31:0]     pendHi, pendLo;
   logic [31:0]     mHi = '0;
   logic [31:0]     mLo = '0;

   // Signed divide with MIPS semantics; the overflow pair is handled explicitly.
   task automatic modelDiv(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] q, output logic [31:0] r);
      int sx, sy;
      sx = x;
      sy = y;
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else begin
         q = sx / sy;
         r = sx % sy;
      end
   endtask

   // Model update on each rising edge, cleared asynchronously by reset.
   always @(posedge clk or negedge reset) begin
      bit              wasBusy;
      longint          sp;
      longint unsigned up;
      logic [31:0]     q, r;
      if (!reset) begin
         doneEdge  = edgeCount;
         pendWrite = 1'b0;
         mHi       = '0;
         mLo       = '0;
      end else begin
         wasBusy = (edgeCount < doneEdge);
         edgeCount++;
         if (pendWrite && edgeCount == doneEdge) begin
            mHi       = pendHi;
            mLo       = pendLo;
            pendWrite = 1'b0;
         end
         if (!wasBusy && start) begin
            case (op)
               3'b000: begin
                  sp = longint'($signed(a)) * longint'($signed(b));
                  {pendHi, pendLo} = sp;
                  pendWrite = 1'b1;
                  doneEdge  = edgeCount + 5;
               end
               3'b001: begin
                  up = {32'h0, a} * {32'h0, b};
                  {pendHi, pendLo} = up;
                  pendWrite = 1'b1;
                  doneEdge  = edgeCount + 5;
               end
               3'b010: begin
                  pendWrite = (b != 0);
                  if (b != 0) begin
                     modelDiv(a, b, q, r);
                     pendLo = q;
                     pendHi = r;
                  end
                  doneEdge = edgeCount + 10;
               end
               3'b011: begin
                  pendWrite = (b != 0);
                  if (b != 0) begin
                     pendLo = a / b;
                     pendHi = a % b;
                  end
                  doneEdge = edgeCount + 10;
               end
               3'b100:  mHi = a;
               3'b101:  mLo = a;
               default: ;
            endcase
         end
      end
   end

   // Every-cycle comparison of busy/hi/lo against the model.
   always @(negedge clk) begin
      if (cmpOn) begin
         checkOutput("model busy", {31'b0, busy}, {31'b0, (edgeCount < doneEdge)});
         checkOutput("model hi", hi, mHi);
         checkOutput("model lo", lo, mLo);
      end
   end

   // Presents one start pulse; caller is positioned at a falling edge.
   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy cycles (bounded) while scrambling the operand inputs.
   task automatic waitIdle(output int n);
      n = 0;
      while (busy && n < 40) begin
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      #2;
      checkOutput("reset busy", {31'b0, busy}, 32'h0);
      checkOutput("reset hi", hi, 32'h0);
      checkOutput("reset lo", lo, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      cmpOn = 1'b1;

      // mult -2 * 3, launched at the first edge out of reset
      applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      waitIdle(n);
      checkOutput("mult busy cycles", n, 32'd5);
      checkOutput("mult hi", hi, 32'hFFFF_FFFF);
      checkOutput("mult lo", lo, 32'hFFFF_FFFA);

      // multu 0xFFFFFFFF * 2
      applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      waitIdle(n);
      checkOutput("multu busy cycles", n, 32'd5);
      checkOutput("multu hi", hi, 32'h0000_0001);
      checkOutput("multu lo", lo, 32'hFFFF_FFFE);

      // div -7 / 2
      applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      waitIdle(n);
      checkOutput("div busy cycles", n, 32'd10);
      checkOutput("div lo", lo, 32'hFFFF_FFFD);
      checkOutput("div hi", hi, 32'hFFFF_FFFF);

      // divu 7 / 0 keeps timing and leaves HI/LO alone
      applyStimulus(MD_DIVU, 32'd7, 32'd0);
      waitIdle(n);
      checkOutput("divu0 busy cycles", n, 32'd10);
      checkOutput("divu0 lo", lo, 32'hFFFF_FFFD);
      checkOutput("divu0 hi", hi, 32'hFFFF_FFFF);

      // signed overflow divide
      applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle(n);
      checkOutput("divovf lo", lo, 32'h8000_0000);
      checkOutput("divovf hi", hi, 32'h0000_0000);

      // mthi / mtlo take effect at once with no busy
      applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0);
      checkOutput("mthi hi", hi, 32'h1234_5678);
      checkOutput("mthi busy", {31'b0, busy}, 32'h0);
      applyStimulus(MD_MTLO, 32'hCAFE_BABE, 32'd0);
      checkOutput("mtlo lo", lo, 32'hCAFE_BABE);
      checkOutput("mtlo hi", hi, 32'h1234_5678);

      // second mult start while busy is ignored
      applyStimulus(MD_MULT, 32'd3, 32'd4);
      applyStimulus(MD_MULT, 32'd100, 32'd100);
      waitIdle(n);
      checkOutput("ignored start busy cycles", n, 32'd4);
      checkOutput("ignored start hi", hi, 32'h0);
      checkOutput("ignored start lo", lo, 32'd12);

      // reset during busy cycle 4 aborts the divide
      applyStimulus(MD_DIV, 32'd50, 32'd3);
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      checkOutput("abort busy", {31'b0, busy}, 32'h0);
      checkOutput("abort hi", hi, 32'h0);
      checkOutput("abort lo", lo, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      checkOutput("abort later hi", hi, 32'h0);
      checkOutput("abort later lo", lo, 32'h0);

      // back-to-back: mult launched in the cycle busy drops after a div
      applyStimulus(MD_DIV, 32'd100, 32'd7);
      waitIdle(n);
      checkOutput("b2b div busy cycles", n, 32'd10);
      checkOutput("b2b div hi", hi, 32'd2);
      checkOutput("b2b div lo", lo, 32'd14);
      applyStimulus(MD_MULT, 32'd6, 32'd7);
      waitIdle(n);
      checkOutput("b2b mult busy cycles", n, 32'd5);
      checkOutput("b2b mult hi", hi, 32'd0);
      checkOutput("b2b mult lo", lo, 32'd42);

      // reserved op is ignored
      applyStimulus(3'b110, 32'hDEAD_BEEF, 32'd1);
      checkOutput("rsv busy", {31'b0, busy}, 32'h0);
      checkOutput("rsv hi", hi, 32'd0);
      checkOutput("rsv lo", lo, 32'd42);

      @(negedge clk);
      cmpOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
